// File: rtl/pwm_fade_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_sequencer
// Brief    : Sequences period/duty writes on the PWM config bus to ramp duty
//            toward a commanded target. Optional back-and-forth "breathe"
//            mode is enabled by defining PWM_FADE_BREATHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_sequencer #(
    parameter int TICK_W   = 16,
    parameter int DUTY_MAX = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [11:0]       cmd_period,
    input  logic [6:0]        cmd_target,
    input  logic [6:0]        cmd_step,
    input  logic [TICK_W-1:0] cmd_interval,
`ifdef PWM_FADE_BREATHE_EN
    input  logic              cmd_loop,
`endif
    input  logic              abort,
    output logic [11:0]       cfg_in,
    output logic              cfg_sel,
    output logic              cfg_wr_en,
    output logic              busy,
    output logic              done,
    output logic [6:0]        cur_duty
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_PER  = 3'd1,
        S_WR_DUTY = 3'd2,
        S_WAIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [6:0] c_duty_max = 7'(DUTY_MAX);

    state_t             r_state,    w_state_nxt;
    logic [11:0]        r_cfg_in,   w_cfg_in_nxt;
    logic               r_cfg_sel,  w_cfg_sel_nxt;
    logic               r_cfg_wr_en, w_cfg_wr_en_nxt;
    logic [6:0]         r_cur_duty, w_cur_duty_nxt;
    logic [TICK_W-1:0]  r_cnt,      w_cnt_nxt;
    logic [6:0]         r_target,   w_target_nxt;
    logic [6:0]         r_step,     w_step_nxt;
    logic [TICK_W-1:0]  r_interval, w_interval_nxt;
    logic               r_cmd_ready, r_busy, r_done;
    logic               w_loop;
`ifdef PWM_FADE_BREATHE_EN
    logic [6:0]         r_start,    w_start_nxt;
    logic               r_loop,     w_loop_nxt;
`endif

    logic [7:0] w_cur8, w_tgt8, w_stp8, w_sum8, w_next8;
    logic [6:0] w_tgt_clamp;

    assign w_tgt_clamp = (cmd_target > c_duty_max) ? c_duty_max : cmd_target;

`ifdef PWM_FADE_BREATHE_EN
    assign w_loop = r_loop;
`else
    assign w_loop = 1'b0;
`endif

    // Next duty step, widened to 8 bits; result never exceeds DUTY_MAX so bit 7 is zero.
    always_comb begin
        w_cur8  = {1'b0, r_cur_duty};
        w_tgt8  = {1'b0, r_target};
        w_stp8  = {1'b0, r_step};
        w_sum8  = w_cur8 + w_stp8;
        w_next8 = w_tgt8;
        if (r_step == 7'd0) begin
            w_next8 = w_tgt8;
        end else if (w_cur8 < w_tgt8) begin
            w_next8 = (w_sum8 > w_tgt8) ? w_tgt8 : w_sum8;
        end else if (w_cur8 >= (w_tgt8 + w_stp8)) begin
            w_next8 = w_cur8 - w_stp8;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cfg_in_nxt    = r_cfg_in;
        w_cfg_sel_nxt   = r_cfg_sel;
        w_cfg_wr_en_nxt = 1'b0;
        w_cur_duty_nxt  = r_cur_duty;
        w_cnt_nxt       = r_cnt;
        w_target_nxt    = r_target;
        w_step_nxt      = r_step;
        w_interval_nxt  = r_interval;
`ifdef PWM_FADE_BREATHE_EN
        w_start_nxt     = r_start;
        w_loop_nxt      = r_loop;
`endif
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_target_nxt    = w_tgt_clamp;
                    w_step_nxt      = cmd_step;
                    w_interval_nxt  = cmd_interval;
`ifdef PWM_FADE_BREATHE_EN
                    w_start_nxt     = r_cur_duty;
                    w_loop_nxt      = cmd_loop;
`endif
                    w_state_nxt     = S_WR_PER;
                    w_cfg_wr_en_nxt = 1'b1;
                    w_cfg_sel_nxt   = 1'b1;
                    w_cfg_in_nxt    = cmd_period;
                end
            end
            S_WR_PER, S_WAIT: begin
                if (r_state == S_WAIT && r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - TICK_W'(1);
                end else begin
                    w_state_nxt     = S_WR_DUTY;
                    w_cfg_wr_en_nxt = 1'b1;
                    w_cfg_sel_nxt   = 1'b0;
                    w_cfg_in_nxt    = {4'b0, w_next8};
                    w_cur_duty_nxt  = w_next8[6:0];
                end
            end
            S_WR_DUTY: begin
                // r_cur_duty already holds the value written this cycle.
                if (r_cur_duty != r_target) begin
                    w_cnt_nxt   = r_interval;
                    w_state_nxt = S_WAIT;
                end else if (w_loop) begin
`ifdef PWM_FADE_BREATHE_EN
                    w_target_nxt = r_start;
                    w_start_nxt  = r_target;
`endif
                    w_cnt_nxt    = r_interval;
                    w_state_nxt  = S_WAIT;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (abort && r_state != S_IDLE) begin
            w_state_nxt     = S_IDLE;
            w_cfg_wr_en_nxt = 1'b0;
            w_cfg_in_nxt    = r_cfg_in;
            w_cfg_sel_nxt   = r_cfg_sel;
            w_cur_duty_nxt  = r_cur_duty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cfg_in    <= '0;
            r_cfg_sel   <= 1'b0;
            r_cfg_wr_en <= 1'b0;
            r_cur_duty  <= '0;
            r_cnt       <= '0;
            r_target    <= '0;
            r_step      <= '0;
            r_interval  <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef PWM_FADE_BREATHE_EN
            r_start     <= '0;
            r_loop      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cfg_in    <= w_cfg_in_nxt;
            r_cfg_sel   <= w_cfg_sel_nxt;
            r_cfg_wr_en <= w_cfg_wr_en_nxt;
            r_cur_duty  <= w_cur_duty_nxt;
            r_cnt       <= w_cnt_nxt;
            r_target    <= w_target_nxt;
            r_step      <= w_step_nxt;
            r_interval  <= w_interval_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
`ifdef PWM_FADE_BREATHE_EN
            r_start     <= w_start_nxt;
            r_loop      <= w_loop_nxt;
`endif
        end
    end

    assign cfg_in    = r_cfg_in;
    assign cfg_sel   = r_cfg_sel;
    assign cfg_wr_en = r_cfg_wr_en;
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cur_duty  = r_cur_duty;

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_fade_sequencer
// Brief    : Directed self-checking bench for pwm_fade_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_sequencer;

    localparam int TICK_W = 16;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [11:0]       cmd_period;
    logic [6:0]        cmd_target;
    logic [6:0]        cmd_step;
    logic [TICK_W-1:0] cmd_interval;
`ifdef PWM_FADE_BREATHE_EN
    logic              cmd_loop;
`endif
    logic              abort;
    logic [11:0]       cfg_in;
    logic              cfg_sel;
    logic              cfg_wr_en;
    logic              busy;
    logic              done;
    logic [6:0]        cur_duty;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;

    pwm_fade_sequencer #(.TICK_W(TICK_W), .DUTY_MAX(100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_period   (cmd_period),
        .cmd_target   (cmd_target),
        .cmd_step     (cmd_step),
        .cmd_interval (cmd_interval),
`ifdef PWM_FADE_BREATHE_EN
        .cmd_loop     (cmd_loop),
`endif
        .abort        (abort),
        .cfg_in       (cfg_in),
        .cfg_sel      (cfg_sel),
        .cfg_wr_en    (cfg_wr_en),
        .busy         (busy),
        .done         (done),
        .cur_duty     (cur_duty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (cfg_wr_en === 1'b1) wr_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer a command for one cycle and check the period write that follows.
    task automatic send(input string tag, input int per, input int tgt, input int stp, input int ivl);
        cmd_period   = per[11:0];
        cmd_target   = tgt[6:0];
        cmd_step     = stp[6:0];
        cmd_interval = ivl[TICK_W-1:0];
        cmd_valid    = 1'b1;
        step();
        cmd_valid    = 1'b0;
        chk({tag, "_per_wr"},  32'(cfg_wr_en), 1);
        chk({tag, "_per_sel"}, 32'(cfg_sel),   1);
        chk({tag, "_per_val"}, 32'(cfg_in),    per);
        chk({tag, "_ready"},   32'(cmd_ready), 0);
        chk({tag, "_busy"},    32'(busy),      1);
    endtask

    // Wait (bounded) for the next write strobe and check spacing and value.
    task automatic next_duty(input string tag, input int exp_val, input int exp_gap);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (cfg_wr_en !== 1'b1 && n < 64);
        chk({tag, "_gap"}, n,               exp_gap);
        chk({tag, "_val"}, 32'(cfg_in),     exp_val);
        chk({tag, "_sel"}, 32'(cfg_sel),    0);
        chk({tag, "_cur"}, 32'(cur_duty),   exp_val);
    endtask

    task automatic finish_done(input string tag, input int exp_cur);
        step();
        chk({tag, "_done"},    32'(done),      1);
        chk({tag, "_done_wr"}, 32'(cfg_wr_en), 0);
        step();
        chk({tag, "_done_lo"}, 32'(done),      0);
        chk({tag, "_idle_rdy"}, 32'(cmd_ready), 1);
        chk({tag, "_idle_bsy"}, 32'(busy),      0);
        chk({tag, "_end_cur"}, 32'(cur_duty),  exp_cur);
    endtask

    initial begin
        int d0;
        int w0;
        rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        cmd_period = '0; cmd_target = '0; cmd_step = '0; cmd_interval = '0;
`ifdef PWM_FADE_BREATHE_EN
        cmd_loop = 1'b0;
`endif
        step();
        step();
        chk("rst_cfg_in", 32'(cfg_in),    0);
        chk("rst_sel",    32'(cfg_sel),   0);
        chk("rst_wr_en",  32'(cfg_wr_en), 0);
        chk("rst_ready",  32'(cmd_ready), 1);
        chk("rst_busy",   32'(busy),      0);
        chk("rst_done",   32'(done),      0);
        chk("rst_cur",    32'(cur_duty),  0);
        rst_n = 1'b1;
        step();

        // Up-ramp 0 -> 50 by 10, interval 3 (writes 5 cycles apart).
        d0 = done_cnt;
        send("up", 1000, 50, 10, 3);
        next_duty("up10", 10, 1);
        next_duty("up20", 20, 5);
        next_duty("up30", 30, 5);
        next_duty("up40", 40, 5);
        next_duty("up50", 50, 5);
        finish_done("up", 50);
        chk("up_done_once", done_cnt - d0, 1);

        // Down-ramp 50 -> 5 by 20, interval 0 (writes 2 cycles apart).
        send("dn", 500, 5, 20, 0);
        next_duty("dn30", 30, 1);
        next_duty("dn10", 10, 2);
        next_duty("dn5",  5,  2);
        finish_done("dn", 5);

        // Clamp 120 -> 100, step 0 jumps; period 0 still written.
        send("clamp", 0, 120, 0, 7);
        next_duty("clamp100", 100, 1);
        finish_done("clamp", 100);

        // Abort in WAIT after the 20 write; cmd_valid while busy is ignored.
        d0 = done_cnt;
        send("ab", 200, 0, 40, 4);
        next_duty("ab60", 60, 1);
        next_duty("ab20", 20, 6);
        cmd_period = 12'd77; cmd_target = 7'd9; cmd_step = 7'd1; cmd_interval = '0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("busy_ign_wr",    32'(cfg_wr_en), 0);
        chk("busy_ign_ready", 32'(cmd_ready), 0);
        chk("busy_ign_busy",  32'(busy),      1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_idle_busy",  32'(busy),      0);
        chk("ab_idle_ready", 32'(cmd_ready), 1);
        chk("ab_idle_wr",    32'(cfg_wr_en), 0);
        chk("ab_cur",        32'(cur_duty),  20);
        w0 = wr_cnt;
        repeat (12) step();
        chk("ab_no_writes", wr_cnt - w0,    0);
        chk("ab_no_done",   done_cnt - d0,  0);
        chk("ab_cur_hold",  32'(cur_duty),  20);

        // Abort in IDLE has no effect on a command offered the same cycle.
        abort = 1'b1;
        send("abidle", 300, 20, 5, 2);
        abort = 1'b0;
        next_duty("abidle20", 20, 1);
        finish_done("abidle", 20);

`ifdef PWM_FADE_BREATHE_EN
        // Return to 0, then breathe 0 <-> 30 by 15 until aborted.
        send("zero", 100, 0, 0, 0);
        next_duty("zero0", 0, 1);
        finish_done("zero", 0);
        d0 = done_cnt;
        cmd_loop = 1'b1;
        send("br", 400, 30, 15, 1);
        cmd_loop = 1'b0;
        next_duty("br15a", 15, 1);
        next_duty("br30a", 30, 3);
        next_duty("br15b", 15, 3);
        next_duty("br0",   0,  3);
        next_duty("br15c", 15, 3);
        next_duty("br30b", 30, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("br_ab_busy", 32'(busy),     0);
        chk("br_ab_cur",  32'(cur_duty), 30);
        chk("br_no_done", done_cnt - d0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
Command-driven controller that sequences the 12-bit configuration bus (in/sel/wr_en) of the PWM generator.
- Accepts one fade command per transaction: period, target duty %, step size and step interval.
- Writes the period once, then ramps duty from its current value to the target.
- Sits between the host/register interface and the PWM generator. It is the only writer of that bus.

Parameters:
- TICK_W, 16: width of the step-interval counter and of cmd_interval.
- DUTY_MAX, 100: maximum legal duty percentage. Targets above it are clamped.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command (IDLE only)
- cmd_period  in  12  PWM period to program
- cmd_target  in  7  target duty %
- cmd_step  in  7  duty increment/decrement per step (0 = jump)
- cmd_interval  in  TICK_W  idle cycles between duty writes
- abort  in  1  stop current fade
- cfg_in  out  12  to PWM in
- cfg_sel  out  1  to PWM sel (1 = period, 0 = duty)
- cfg_wr_en  out  1  to PWM wr_en
- busy  out  1  fade in progress
- done  out  1  one-cycle pulse, fade reached target
- cur_duty  out  7  last duty value written

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, cfg_in=0, cfg_sel=0, cfg_wr_en=0, cmd_ready=1, busy=0, done=0, cur_duty=0, tick counter=0.
  - Reset mid-fade aborts immediately. No further writes are issued.
- All outputs are registered.
- cfg_wr_en is high for exactly one cycle per write. cfg_in/cfg_sel are valid in that same cycle.
- States: IDLE, WR_PER, WR_DUTY, WAIT, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&&cmd_ready, latch all cmd_* fields and go to WR_PER.
  - target is latched as min(cmd_target, DUTY_MAX).
  - cmd_valid outside IDLE is ignored. There is no queueing.
- WR_PER (1 cycle): cfg_wr_en=1, cfg_sel=1, cfg_in=period. Next state WR_DUTY.
  - The period is written unconditionally, including 0.
- WR_DUTY (1 cycle):
  - next = cur<target ? min(cur+step, target) : max(cur-step, target).
  - Compute in 8 bits so there is no wrap or underflow.
  - step=0 gives next=target.
  - cur=target gives next=target, i.e. a single write of the unchanged value.
  - Outputs: cfg_wr_en=1, cfg_sel=0, cfg_in={5'b0, next}. cur_duty<=next.
  - If next==target, go to DONE. Otherwise load tick counter = interval and go to WAIT.
- WAIT:
  - If counter==0, go to WR_DUTY. Otherwise decrement.
  - WAIT lasts interval+1 cycles, so consecutive duty write strobes are interval+2 cycles apart.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in every state except IDLE.
- cmd_ready goes low the cycle after acceptance and returns high the cycle after DONE.
- abort:
  - Sampled in any non-IDLE state; it takes priority over every transition.
  - Next state is IDLE. cfg_wr_en is 0 from the next cycle. No done pulse. cur_duty keeps the last written value.
  - Abort in IDLE has no effect.
- cur_duty persists across commands, so a new fade starts from the previous endpoint.

Optional Feature:
- Macro: PWM_FADE_BREATHE_EN.
- Defined:
  - Adds input cmd_loop (1 bit), latched with the command.
  - If loop=1 and WR_DUTY reaches target, the sequencer swaps target with the start duty latched at acceptance, then enters WAIT instead of DONE.
  - Fades continue back and forth indefinitely. done never pulses. Only abort or reset ends the fade.
- Undefined: the port is absent and the block behaves as loop=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all outputs at reset values, cmd_ready=1.
- Up-ramp, cur=0: period=1000, target=50, step=10, interval=3 -> wr(sel=1, 1000), then duty writes 10,20,30,40,50 spaced 5 cycles, done 1 cycle after the 50 write, cur_duty=50.
- Down-ramp from 50: target=5, step=20, interval=0 -> duty writes 30,10,5 spaced 2 cycles, no underflow, done pulses.
- Clamp and jump: target=120, step=0 -> single duty write of 100.
- Abort during WAIT after the 20 write -> IDLE next cycle, no more wr_en, no done, cur_duty=20. cmd_valid while busy -> not accepted.
- PWM_FADE_BREATHE_EN, loop=1: 0->30, step 15 -> writes 15,30,15,0,15,... until abort. done never asserted.
